// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, DATA_WIDTH data bits LSB-first,
// optional parity bit, stop bit, one serial bit per baud-tick clock edge.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  par_bit,
    output logic [DATA_WIDTH-1:0] par_data,
    output logic                  par_valid,
    output logic                  par_type,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_par_en;

    logic [2:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_par_en_nxt;
    logic [DATA_WIDTH-1:0] w_par_data_nxt;
    logic                  w_par_type_nxt;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;

    // State register and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            par_data  <= '0;
            par_type  <= 1'b0;
            par_valid <= 1'b0;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_par_en  <= w_par_en_nxt;
            par_data  <= w_par_data_nxt;
            par_type  <= w_par_type_nxt;
            par_valid <= w_busy_nxt;
            TX_OUT    <= w_tx_nxt;
            busy      <= w_busy_nxt;
        end
    end

    // Next state; outputs are derived from the state being entered so the
    // registered line always matches the state currently held.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_par_en_nxt   = r_par_en;
        w_par_data_nxt = par_data;
        w_par_type_nxt = par_type;
        w_tx_nxt       = 1'b1;
        w_busy_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (Data_Valid) begin
                    w_state_nxt    = START;
                    w_shift_nxt    = P_DATA;
                    w_par_data_nxt = P_DATA;
                    w_par_en_nxt   = PAR_EN;
                    w_par_type_nxt = PAR_TYP;
                end
            end
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
            end
            DATA: begin
                w_shift_nxt = r_shift >> 1;
                if (r_cnt == LAST_BIT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PARITY:  w_state_nxt = STOP;
            STOP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = par_bit;
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level queue model of the serial
// line, directed frames from the plan plus randomized request traffic.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       par_bit;
    logic [7:0] par_data;
    logic       par_valid;
    logic       par_type;
    logic       TX_OUT;
    logic       busy;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .par_bit    (par_bit),
        .par_data   (par_data),
        .par_valid  (par_valid),
        .par_type   (par_type),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // External parity calculator: even parity for type 0, odd for type 1
    assign par_bit = (^par_data) ^ par_type;

    int          n_vec = 0;
    int          n_err = 0;
    bit          q[$];
    bit          m_busy = 1'b0;
    bit          m_tx = 1'b1;
    logic [7:0]  m_data = 8'h00;
    logic        m_type = 1'b0;
    logic [31:0] cap = '0;
    int          busy_cnt = 0;
    int          cyc = 0;
    int          last_rise = -1;
    int          last_gap = 0;
    bit          prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_tx   = 1'b1;
        m_data = 8'h00;
        m_type = 1'b0;
    endtask

    // One clock edge of the line model: play out queued frame bits, then one idle cycle
    task automatic model_edge(input bit dv, input logic [7:0] d, input bit en, input bit typ);
        if (q.size() != 0) begin
            m_tx   = q.pop_front();
            m_busy = 1'b1;
        end else if (m_busy) begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else if (dv) begin
            m_data = d;
            m_type = typ;
            q.push_back(1'b0);
            for (int i = 0; i < 8; i++) q.push_back(d[i]);
            if (en) q.push_back((^d) ^ typ);
            q.push_back(1'b1);
            m_tx   = q.pop_front();
            m_busy = 1'b1;
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    task automatic step(input bit dv, input logic [7:0] d, input bit en, input bit typ);
        @(negedge CLK);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = en;
        PAR_TYP    = typ;
        @(posedge CLK);
        model_edge(dv, d, en, typ);
        #1;
        cyc++;
        check("tx_out", 32'(TX_OUT), 32'(m_tx));
        check("busy", 32'(busy), 32'(m_busy));
        check("par_valid", 32'(par_valid), 32'(m_busy));
        check("par_data", 32'(par_data), 32'(m_data));
        check("par_type", 32'(par_type), 32'(m_type));
        cap = {cap[30:0], TX_OUT};
        if (busy) busy_cnt++;
        if (busy && !prev_busy) begin
            if (last_rise >= 0) last_gap = cyc - last_rise;
            last_rise = cyc;
        end
        prev_busy = busy;
    endtask

    task automatic idle_step();
        step(1'b0, 8'($urandom()), 1'($urandom()), 1'($urandom()));
    endtask

    // Request one frame and run 12 cycles; optionally inject a request at cycle inj
    task automatic frame(input logic [7:0] d, input bit en, input bit typ, input int inj);
        cap      = '0;
        busy_cnt = 0;
        step(1'b1, d, en, typ);
        for (int i = 1; i < 12; i++) begin
            if (i == inj) step(1'b1, 8'hFF, ~en, ~typ);
            else          idle_step();
        end
    endtask

    task automatic reset_check();
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_par_valid", 32'(par_valid), 32'd0);
        check("rst_par_data", 32'(par_data), 32'd0);
        check("rst_par_type", 32'(par_type), 32'd0);
    endtask

    initial begin
        #2 RST = 1'b0;
        #1;
        model_reset();
        reset_check();
        #10 RST = 1'b1;
        prev_busy = 1'b0;

        idle_step();
        idle_step();

        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1 then idle
        frame(8'hA5, 1'b1, 1'b0, 0);
        check("a5_frame", cap & 32'hFFF, 32'h52B);
        check("a5_busy_len", 32'(busy_cnt), 32'd11);

        // 0x01 odd parity: parity bit 0
        frame(8'h01, 1'b1, 1'b1, 0);
        check("01_frame", cap & 32'hFFF, 32'h403);

        // 0x3C no parity: 10-cycle frame
        frame(8'h3C, 1'b0, 1'b0, 0);
        check("3c_frame", cap & 32'hFFF, 32'h1E7);
        check("3c_busy_len", 32'(busy_cnt), 32'd10);

        // Mid-frame request is dropped, current frame unaffected
        frame(8'hA5, 1'b1, 1'b0, 4);
        check("drop_frame", cap & 32'hFFF, 32'h52B);
        for (int i = 0; i < 3; i++) idle_step();
        check("drop_idle", 32'(busy), 32'd0);

        // Data_Valid held high: 12 cycles between frame starts
        last_rise = -1;
        last_gap  = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 8'h55, 1'b1, 1'b0);
        check("held_gap", 32'(last_gap), 32'd12);
        for (int i = 0; i < 13; i++) idle_step();

        // Reset during data bit 4, then a full frame afterwards
        step(1'b1, 8'h96, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle_step();
        #2 RST = 1'b0;
        #1;
        model_reset();
        reset_check();
        @(negedge CLK);
        RST = 1'b1;
        prev_busy = 1'b0;
        frame(8'hC3, 1'b1, 1'b1, 0);
        check("post_rst_frame", cap & 32'hFFF, 32'h61F);

        // Randomized request traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) == 0), 8'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        for (int i = 0; i < 13; i++) idle_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
